countdown_timer_fsm: RTL and testbench
======================================

# countdown_timer_fsm

Parametrised countdown timer controller for the board-level top: loads a start value from switches, displays it, counts it down at a programmable tick rate with pause/resume, and flashes the LED bank on expiry. It replaces the earlier fixed 8-bit, reset-less controller. It adds async reset, edge-detected buttons, pause/resume, reload-on-restart and a parametrised width/rate. Its `count` and `disp_en` outputs feed the existing seven-segment display driver.

## Interface
- `WIDTH`, 8: count and start-value width.
- `TICK_DIV`, 100_000_000: clk cycles per count decrement; must be ≥2.
- `FLASH_DIV`, 50_000_000: clk cycles per LED flash half-period; must be ≥2.
- `LED_W`, 16: LED bank width.
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sw`  in  WIDTH  start value, sampled in SET.
- `btn_set`  in  1  raw set button, asynchronous level.
- `btn_go`  in  1  raw go/pause button, asynchronous level.
- `count`  out  WIDTH  value to display.
- `disp_en`  out  1  display enable.
- `done`  out  1  high while in DONE.
- `state`  out  3  current state encoding, for debug.
- `led`  out  LED_W  flash output.

## Operation
- Each button passes through a 2-flop synchroniser and a rising-edge detector. The result is a 1-cycle event: `set_ev` or `go_ev`. Held buttons produce one event only.
- A `set_ev` in any state moves to SET. It has priority over `go_ev` in the same cycle.
- **IDLE**: `count`=0, `disp_en`=0. `set_ev` moves to SET.
- **SET**: `count`<=`sw` every cycle, `disp_en`=1. On `go_ev` with `sw`≠0, latch `start`<=`sw` and move to ARMED. A `go_ev` with `sw`=0 is ignored.
- **ARMED**: `count` holds `start`, `disp_en`=1. On `go_ev`, clear the prescaler and move to RUN.
- **RUN**: the prescaler counts 0..TICK_DIV-1. At wrap, `tick`=1 and `count` decrements.
  - `tick` with `count`=1 moves to DONE with `count`=0. This has priority over `go_ev`.
  - Otherwise `go_ev` moves to PAUSE. A coincident tick still decrements.
- **PAUSE**: the prescaler and `count` hold. `go_ev` returns to RUN and the prescaler resumes from its held value.
- **DONE**: `count`=0, `done`=1. The flash phase starts at 1 and toggles every FLASH_DIV cycles.
  - `led` is all ones when phase=1 and zero when phase=0.
  - `go_ev` reloads `count`<=`start` and moves to ARMED.
- `led`=0 in every state except DONE.
- `count` never wraps below 0. The decrement applies only in RUN with `count`>0.
- Reset, mid-operation or not, forces IDLE. Reset values:
  - `count`=0, `start`=0, `disp_en`=0, `done`=0, `led`=0.
  - Prescaler=0, flash counter=0, phase=0, synchroniser flops=0.
- All outputs are registered.

## Timing
- Button rise sampled at edge k gives its event at edge k+2. The state and output change is visible after edge k+3.
- The first decrement occurs TICK_DIV cycles after entering RUN from ARMED. After that, one decrement occurs every TICK_DIV cycles spent in RUN.
- The LEDs light on the first cycle in DONE. The first toggle comes FLASH_DIV cycles later.
- Total run time from RUN entry to DONE entry is `start`×TICK_DIV cycles, excluding paused cycles.

## Structure
- Package `timer_pkg` holds:
  - the `timer_state_t` enum: IDLE=0, SET=1, ARMED=2, RUN=3, PAUSE=4, DONE=5;
  - the widths of the debug state output.
- Sub-module `btn_edge`: 2-flop synchroniser plus rising-edge pulse, reset to 0. It is instantiated twice.
- Prescaler, flash divider and FSM live in the top module. Counter widths are derived with `$clog2` of the divider parameters.

## Test plan
All scenarios use WIDTH=8, TICK_DIV=4, FLASH_DIV=3.
- Reset: drive `rst_n`=0 mid-RUN. All outputs go to 0 immediately, state is IDLE. Release reset; nothing changes without a button.
- Load and run: `set` pulse, `sw`=3, then `go`, then `go`.
  - `count` steps 3→2→1→0 at 4-cycle spacing.
  - `done`=1 and `led`=16'hFFFF on DONE entry.
  - `led` toggles every 3 cycles.
- Pause: `sw`=5, run, press `go` after 6 cycles in RUN.
  - `count` holds at 4 for 20 cycles.
  - Second `go`: next decrement to 3 arrives 2 cycles later, from the held prescaler.
- Zero/hold:
  - `sw`=0 in SET plus `go`: stays in SET.
  - Hold `btn_go` high 50 cycles in ARMED: exactly one transition, to RUN.
- Priority:
  - `btn_set` and `btn_go` rise together in RUN: ends in SET.
  - `go_ev` coincident with the final tick at `count`=1: ends in DONE.
- Restart: `go` in DONE with `start`=7 gives ARMED, `count`=7, `led`=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: state encoding and debug-port width.
package timer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    ARMED = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } timer_state_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button plus a registered one-cycle rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync0;
  logic sync1;
  logic sync1_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      sync1_prev <= 1'b0;
      pulse      <= 1'b0;
    end else begin
      sync0      <= btn;
      sync1      <= sync0;
      sync1_prev <= sync1;
      pulse      <= sync1 & ~sync1_prev;
    end
  end

endmodule

// File: rtl/countdown_timer_fsm.sv
// Countdown timer controller: loads from switches, counts down at a programmable
// tick rate with pause/resume, and flashes the LED bank on expiry.
module countdown_timer_fsm
  import timer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 100_000_000,
  parameter int FLASH_DIV = 50_000_000,
  parameter int LED_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sw,
  input  logic               btn_set,
  input  logic               btn_go,
  output logic [WIDTH-1:0]   count,
  output logic               disp_en,
  output logic               done,
  output logic [STATE_W-1:0] state,
  output logic [LED_W-1:0]   led
);

  localparam int PRE_W   = $clog2(TICK_DIV);
  localparam int FLASH_W = $clog2(FLASH_DIV);
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_MAX = FLASH_W'(FLASH_DIV - 1);

  logic set_ev;
  logic go_ev;

  btn_edge u_set_edge (.clk(clk), .rst_n(rst_n), .btn(btn_set), .pulse(set_ev));
  btn_edge u_go_edge  (.clk(clk), .rst_n(rst_n), .btn(btn_go),  .pulse(go_ev));

  timer_state_t        cur_state, state_next;
  logic [WIDTH-1:0]    count_next, start, start_next;
  logic [PRE_W-1:0]    pre, pre_next;
  logic [FLASH_W-1:0]  flash_cnt, flash_next;
  logic                phase, phase_next;
  logic                tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      count     <= '0;
      start     <= '0;
      pre       <= '0;
      flash_cnt <= '0;
      phase     <= 1'b0;
      disp_en   <= 1'b0;
      done      <= 1'b0;
      led       <= '0;
    end else begin
      cur_state <= state_next;
      count     <= count_next;
      start     <= start_next;
      pre       <= pre_next;
      flash_cnt <= flash_next;
      phase     <= phase_next;
      disp_en   <= (state_next != IDLE);
      done      <= (state_next == DONE);
      led       <= (state_next == DONE && phase_next) ? {LED_W{1'b1}} : '0;
    end
  end

  assign state = cur_state;
  assign tick  = (cur_state == RUN) && (pre == PRE_MAX);

  always_comb begin
    state_next = cur_state;
    count_next = count;
    start_next = start;
    pre_next   = pre;
    flash_next = '0;
    phase_next = 1'b0;

    case (cur_state)
      IDLE: count_next = '0;
      SET: begin
        count_next = sw;
        if (go_ev && sw != '0) begin
          start_next = sw;
          state_next = ARMED;
        end
      end
      ARMED: begin
        count_next = start;
        if (go_ev) begin
          pre_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        pre_next = tick ? '0 : pre + 1'b1;
        // Expiry beats a coincident pause request.
        if (tick && count == WIDTH'(1)) begin
          count_next = '0;
          state_next = DONE;
        end else begin
          if (tick && count != '0) count_next = count - 1'b1;
          if (go_ev) state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (go_ev) state_next = RUN;
      end
      DONE: begin
        count_next = '0;
        if (flash_cnt == FLASH_MAX) begin
          flash_next = '0;
          phase_next = ~phase;
        end else begin
          flash_next = flash_cnt + 1'b1;
          phase_next = phase;
        end
        if (go_ev) begin
          count_next = start;
          state_next = ARMED;
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase

    if (set_ev) begin
      state_next = SET;
      count_next = sw;
    end

    // Flash always starts lit on DONE entry and is idle everywhere else.
    if (state_next != DONE) begin
      flash_next = '0;
      phase_next = 1'b0;
    end else if (cur_state != DONE) begin
      flash_next = '0;
      phase_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_countdown_timer_fsm.sv
// Directed self-checking bench for countdown_timer_fsm with small dividers.
module tb_countdown_timer_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic        btn_set;
  logic        btn_go;
  logic [7:0]  count;
  logic        disp_en;
  logic        done;
  logic [2:0]  state;
  logic [15:0] led;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] S_IDLE  = 0;
  localparam logic [31:0] S_SET   = 1;
  localparam logic [31:0] S_ARMED = 2;
  localparam logic [31:0] S_RUN   = 3;
  localparam logic [31:0] S_PAUSE = 4;
  localparam logic [31:0] S_DONE  = 5;

  countdown_timer_fsm #(
    .WIDTH(8), .TICK_DIV(4), .FLASH_DIV(3), .LED_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_set(btn_set), .btn_go(btn_go),
    .count(count), .disp_en(disp_en), .done(done), .state(state), .led(led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle button pulse; returns just after the FSM has reacted (3 edges later).
  task automatic applyStimulus(input logic set_v, input logic go_v);
    btn_set = set_v;
    btn_go  = go_v;
    @(negedge clk);
    btn_set = 1'b0;
    btn_go  = 1'b0;
    waitCycles(3);
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'd0; btn_set = 1'b0; btn_go = 1'b0;
    waitCycles(2);
    checkOutput("rst_state", 32'(state), S_IDLE);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_led", 32'(led), 0);
    rst_n = 1'b1;
    waitCycles(5);
    checkOutput("idle_state", 32'(state), S_IDLE);
    checkOutput("idle_disp", 32'(disp_en), 0);

    // Load and run from 3
    sw = 8'd3;
    applyStimulus(1'b1, 1'b0);
    checkOutput("set_state", 32'(state), S_SET);
    checkOutput("set_count", 32'(count), 3);
    checkOutput("set_disp", 32'(disp_en), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("armed_state", 32'(state), S_ARMED);
    applyStimulus(1'b0, 1'b1);
    checkOutput("run_state", 32'(state), S_RUN);
    checkOutput("run_count0", 32'(count), 3);
    waitCycles(3);
    checkOutput("run_count_pre", 32'(count), 3);
    waitCycles(1);
    checkOutput("run_count1", 32'(count), 2);
    waitCycles(4);
    checkOutput("run_count2", 32'(count), 1);
    waitCycles(4);
    checkOutput("done_state", 32'(state), S_DONE);
    checkOutput("done_count", 32'(count), 0);
    checkOutput("done_flag", 32'(done), 1);
    checkOutput("done_led0", 32'(led), 32'h0000FFFF);
    waitCycles(2);
    checkOutput("done_led_hold", 32'(led), 32'h0000FFFF);
    waitCycles(1);
    checkOutput("done_led_off", 32'(led), 0);
    waitCycles(3);
    checkOutput("done_led_on", 32'(led), 32'h0000FFFF);

    // Restart with start=7
    sw = 8'd7;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rs_set_led", 32'(led), 0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitCycles(28);
    checkOutput("rs_done", 32'(state), S_DONE);
    sw = 8'd9;
    applyStimulus(1'b0, 1'b1);
    checkOutput("rs_armed", 32'(state), S_ARMED);
    checkOutput("rs_count", 32'(count), 7);
    checkOutput("rs_led", 32'(led), 0);
    checkOutput("rs_done_flag", 32'(done), 0);

    // Pause after 6 cycles in RUN
    sw = 8'd5;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitCycles(2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pause_state", 32'(state), S_PAUSE);
    checkOutput("pause_count", 32'(count), 4);
    waitCycles(20);
    checkOutput("pause_hold", 32'(count), 4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("resume_state", 32'(state), S_RUN);
    waitCycles(1);
    checkOutput("resume_count1", 32'(count), 4);
    waitCycles(1);
    checkOutput("resume_count2", 32'(count), 3);

    // go with sw=0 is ignored
    sw = 8'd0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("zero_state", 32'(state), S_SET);
    checkOutput("zero_count", 32'(count), 0);

    // Held go button yields a single event
    sw = 8'd200;
    waitCycles(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("hold_armed", 32'(state), S_ARMED);
    checkOutput("hold_count", 32'(count), 200);
    btn_go = 1'b1;
    waitCycles(50);
    checkOutput("hold_run", 32'(state), S_RUN);
    btn_go = 1'b0;
    waitCycles(5);
    checkOutput("hold_release", 32'(state), S_RUN);

    // set and go together in RUN: set wins
    sw = 8'd4;
    applyStimulus(1'b1, 1'b1);
    checkOutput("prio_set", 32'(state), S_SET);
    checkOutput("prio_set_cnt", 32'(count), 4);

    // go coincident with final tick: DONE wins
    sw = 8'd1;
    waitCycles(1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("prio_done", 32'(state), S_DONE);
    checkOutput("prio_done_cnt", 32'(count), 0);
    checkOutput("prio_done_led", 32'(led), 32'h0000FFFF);

    // Async reset mid-RUN
    sw = 8'd9;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitCycles(3);
    checkOutput("mid_run", 32'(state), S_RUN);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_state", 32'(state), S_IDLE);
    checkOutput("arst_count", 32'(count), 0);
    checkOutput("arst_disp", 32'(disp_en), 0);
    checkOutput("arst_done", 32'(done), 0);
    checkOutput("arst_led", 32'(led), 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(6);
    checkOutput("post_rst_state", 32'(state), S_IDLE);
    checkOutput("post_rst_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
